uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, legal 2..8.
REQ-002 SHALL have parameter DBIT, default 8: data width per byte.
REQ-003 SHALL have parameter IW, default 2: grant index width, ceil(log2(NREQ)).
REQ-004 SHALL have port clk  input  1: clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  NREQ: bit i set means requester i offers a byte.
REQ-007 SHALL have port req_data  input  NREQ*DBIT: byte of requester i on bits [i*DBIT +: DBIT].
REQ-008 SHALL have port req_last  input  NREQ: bit i marks the final byte of a requester-i packet.
REQ-009 SHALL have port req_ready  output  NREQ: one-hot accept strobe; byte i is consumed when req_valid[i] and req_ready[i] are both high.
REQ-010 SHALL have port tx_start  output  1: one-cycle start pulse to the UART transmitter.
REQ-011 SHALL have port tx_din  output  DBIT: byte presented to the transmitter.
REQ-012 SHALL have port tx_done_tick  input  1: one-cycle pulse from the transmitter when the stop bit completes.
REQ-013 SHALL have port grant_id  output  IW: index of the requester currently owning the transmitter.
REQ-014 SHALL have port busy  output  1: high in states ISSUE and WAIT.

Function
REQ-015 SHALL implement an FSM with states IDLE, ISSUE and WAIT.
REQ-016 In IDLE, if any req_valid bit is set, the block SHALL select a winner round-robin, searching from (last_grant+1) mod NREQ upward with wrap.
REQ-017 In the IDLE selection cycle, the block SHALL assert req_ready only for the winner, latch the winner's byte into the tx_din register, set grant_id, and go to ISSUE.
REQ-018 In ISSUE, the block SHALL assert tx_start for exactly one cycle and go to WAIT.
REQ-019 The request-to-start latency SHALL be 1 cycle: tx_start rises in the cycle after the accept.
REQ-020 In WAIT, the block SHALL hold tx_din and grant_id stable; on tx_done_tick it SHALL update last_grant to grant_id and return to IDLE.
REQ-021 The block SHALL ignore tx_done_tick in IDLE and ISSUE.
REQ-022 With req_valid all zero in IDLE, the block SHALL stay in IDLE with req_ready equal to 0.
REQ-023 A requester that drops req_valid before it is accepted SHALL lose the arbitration without any side effect.
REQ-024 req_ready SHALL never be asserted outside IDLE, and at most one bit of it SHALL be high in any cycle.
REQ-025 A continuously valid requester SHALL be served at least once every NREQ transmitted bytes, or packets when the lock is enabled (no starvation).

Reset
REQ-026 On reset, the block SHALL set the state to IDLE, last_grant to NREQ-1 (requester 0 has first priority), grant_id to 0, tx_din to 0, tx_start to 0, req_ready to 0, busy to 0, and clear the lock.
REQ-027 A reset asserted in ISSUE or WAIT SHALL abort the transfer immediately; the latched byte is discarded and no tx_start is issued after reset deasserts until a new accept occurs.

Configuration
REQ-028 The macro UART_TX_ARB_LOCK_EN, when defined, SHALL enable packet locking.
- A byte accepted with req_last=0 sets the lock.
- While locked, IDLE considers only req_valid[grant_id]; other requesters wait even if valid.
- Accepting a byte with req_last=1 clears the lock; last_grant updates normally.
REQ-029 When UART_TX_ARB_LOCK_EN is undefined, the block SHALL ignore req_last, include no lock register, and arbitrate on every byte.

Verification
REQ-030 Verification SHALL cover single requester: req_valid=0001, data 0x55 -> req_ready=0001 for 1 cycle, tx_start 1 cycle later with tx_din=0x55, busy until tx_done_tick.
REQ-031 Verification SHALL cover round-robin: req_valid=1111 held, bytes A0..A3 -> transmit order 0,1,2,3,0, with exactly one accept per tx_done_tick.
REQ-032 Verification SHALL cover a late request: requester 2 valid during WAIT of requester 0, and requesters 1 and 2 valid in the next IDLE -> requester 1 granted first, then requester 2.
REQ-033 Verification SHALL cover lock (macro defined): requester 0 sends 3 bytes, last on the third, while requester 1 is valid -> bytes 0,0,0 then 1; with the macro undefined -> bytes 0,1,0,1,0.
REQ-034 Verification SHALL cover reset mid-WAIT: reset pulse while grant_id=3 -> all outputs at reset values, and the next accept goes to the lowest valid index starting at 0.
REQ-035 Verification SHALL cover a spurious done: tx_done_tick in IDLE and in ISSUE -> no state change and no extra accept.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester handshake and the UART transmitter hookup used by
// uart_tx_arbiter.
//   master : arbiter side (consumes requests, drives the transmitter)
//   slave  : environment side (requesters and transmitter)
// Signals:
//   req_valid[NREQ], req_data[NREQ*DBIT], req_last[NREQ]  requester -> arbiter
//   req_ready[NREQ]                                       arbiter -> requester
//   tx_start, tx_din[DBIT]                                arbiter -> transmitter
//   tx_done_tick                                          transmitter -> arbiter
//   grant_id[IW], busy                                    arbiter status
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DBIT = 8,
    parameter int IW   = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_start;
    logic [DBIT-1:0]      tx_din;
    logic                 tx_done_tick;
    logic [IW-1:0]        grant_id;
    logic                 busy;

    modport master (
        input  req_valid, req_data, req_last, tx_done_tick,
        output req_ready, tx_start, tx_din, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, tx_done_tick,
        input  req_ready, tx_start, tx_din, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// A byte is accepted in IDLE (one-hot req_ready), a one-cycle tx_start follows
// in ISSUE, and the block sits in WAIT until the transmitter's tx_done_tick.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : uart_tx_arbiter_if.master (requests, transmitter, status)
// Build option:
//   UART_TX_ARB_LOCK_EN - when defined, a byte accepted with req_last=0 locks
//   the transmitter to that requester until its req_last=1 byte is accepted.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ = 4,
    parameter int DBIT = 8,
    parameter int IW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_arbiter_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [DBIT-1:0] din_q, din_d;
    logic            tx_start_q, tx_start_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] elig_s;
    logic [NREQ-1:0] ready_s;
    logic [IW-1:0]   winner_s;
    logic            found_s;

`ifdef UART_TX_ARB_LOCK_EN
    logic            lock_q, lock_d;

    // Candidate set: only the lock owner may compete while a packet is open
    always_comb begin
        elig_s = {NREQ{1'b0}};
        if (lock_q) begin
            elig_s[grant_q] = bus.req_valid[grant_q];
        end else begin
            elig_s = bus.req_valid;
        end
    end
`else
    // req_last only matters for packet locking
    logic unused_last_s;
    assign unused_last_s = ^bus.req_last;

    // Candidate set: every valid requester competes on every byte
    always_comb begin
        elig_s = bus.req_valid;
    end
`endif

    // Round-robin search starting just after the last served requester
    always_comb begin
        found_s  = 1'b0;
        winner_s = {IW{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (int'(last_q) + k) % NREQ;
            if (!found_s && elig_s[IW'(c)]) begin
                found_s  = 1'b1;
                winner_s = IW'(c);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Next-state and accept logic
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        din_d      = din_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        ready_s    = {NREQ{1'b0}};
`ifdef UART_TX_ARB_LOCK_EN
        lock_d     = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    ready_s[winner_s] = 1'b1;
                    grant_d    = winner_s;
                    din_d      = bus.req_data[int'(winner_s)*DBIT +: DBIT];
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_d     = ~bus.req_last[winner_s];
`endif
                end else begin
                    state_d    = IDLE;
                end
            end
            ISSUE: begin
                // Done ticks here belong to nothing we started; ignore them
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.tx_done_tick) begin
                    last_d  = grant_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= IW'(NREQ - 1);
            grant_q    <= {IW{1'b0}};
            din_q      <= {DBIT{1'b0}};
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            din_q      <= din_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    // Packet lock register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    // The accept strobe is combinational from req_valid, so it is forced low
    // while reset is held to guarantee nothing is consumed during reset.
    assign bus.req_ready = reset ? {NREQ{1'b0}} : ready_s;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_din    = din_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int DBIT = 8;
    localparam int IW   = 2;

    logic clk;
    logic reset;
    uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT), .IW(IW)) bif();

    uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .IW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // requester byte queues (ring buffers)
    logic [7:0] mem_d [NREQ][64];
    bit         mem_l [NREQ][64];
    int         head  [NREQ];
    int         tail  [NREQ];

    // behavioural model: 0 = free, 1 = start due, 2 = transmitting
    int  m_phase, m_last, m_grant, m_din;
`ifdef UART_TX_ARB_LOCK_EN
    bit  m_lock;
`endif
    int  wait_cnt;
    int  fixed_wait;
    bit  rnd_mode;
    bit  spur_force;
    int  log_id[$];
    int  log_dat[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(logic [NREQ-1:0] elig, int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (elig[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic push(int r, logic [7:0] d, bit l);
        mem_d[r][tail[r] % 64] = d;
        mem_l[r][tail[r] % 64] = l;
        tail[r]++;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (tail[i] != head[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_last = NREQ - 1; m_grant = 0; m_din = 0;
`ifdef UART_TX_ARB_LOCK_EN
        m_lock = 1'b0;
`endif
        log_id.delete(); log_dat.delete();
    endtask

    task automatic drive();
        logic [NREQ-1:0]      v;
        logic [NREQ-1:0]      l;
        logic [NREQ*DBIT-1:0] d;
        for (int i = 0; i < NREQ; i++) begin
            bit drop;
            drop = rnd_mode && ($urandom_range(0, 3) == 0);
            if (tail[i] != head[i] && !drop) begin
                v[i] = 1'b1;
                d[i*DBIT +: DBIT] = mem_d[i][head[i] % 64];
                l[i] = mem_l[i][head[i] % 64];
            end else begin
                v[i] = 1'b0;
                d[i*DBIT +: DBIT] = 8'($urandom);
                l[i] = 1'($urandom);
            end
        end
        bif.req_valid = v;
        bif.req_data  = d;
        bif.req_last  = l;
        if (m_phase == 2) begin
            if (wait_cnt == 0) bif.tx_done_tick = 1'b1;
            else begin bif.tx_done_tick = 1'b0; wait_cnt--; end
        end else begin
            bif.tx_done_tick = rnd_mode ? ($urandom_range(0, 2) == 0) : spur_force;
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] elig;
        logic [NREQ-1:0] exp_rdy;
        int p;
        @(negedge clk);
        elig = bif.req_valid;
`ifdef UART_TX_ARB_LOCK_EN
        if (m_lock) elig = bif.req_valid & (NREQ'(1) << m_grant);
`endif
        p = rr_pick(elig, m_last);
        exp_rdy = '0;
        if (m_phase == 0 && p >= 0) exp_rdy[p] = 1'b1;
        chk("req_ready", 32'(bif.req_ready), 32'(exp_rdy));
        chk("tx_start",  32'(bif.tx_start),  32'(m_phase == 1));
        chk("busy",      32'(bif.busy),      32'(m_phase != 0));
        chk("tx_din",    32'(bif.tx_din),    32'(m_din));
        chk("grant_id",  32'(bif.grant_id),  32'(m_grant));
        case (m_phase)
            0: if (p >= 0) begin
                m_grant = p;
                m_din   = int'(bif.req_data[p*DBIT +: DBIT]);
`ifdef UART_TX_ARB_LOCK_EN
                m_lock  = !bif.req_last[p];
`endif
                head[p]++;
                log_id.push_back(p);
                log_dat.push_back(m_din);
                m_phase = 1;
            end
            1: begin
                m_phase  = 2;
                wait_cnt = rnd_mode ? int'($urandom_range(0, 5)) : fixed_wait;
            end
            default: if (bif.tx_done_tick) begin
                m_last  = m_grant;
                m_phase = 0;
            end
        endcase
        @(posedge clk); #1;
    endtask

    task automatic cycle();
        drive();
        step();
    endtask

    task automatic run_drain(int budget);
        int c = 0;
        while (!(all_empty() && m_phase == 0) && c < budget) begin
            cycle();
            c++;
        end
        chk("drain_timeout", 32'(c < budget), 32'd1);
    endtask

    // called just after a rising edge; checks outputs while reset is held
    task automatic do_reset();
        drive();
        #2 reset = 1'b1;
        #2;
        chk("rst_req_ready", 32'(bif.req_ready), 32'd0);
        chk("rst_tx_start",  32'(bif.tx_start),  32'd0);
        chk("rst_busy",      32'(bif.busy),      32'd0);
        chk("rst_grant_id",  32'(bif.grant_id),  32'd0);
        chk("rst_tx_din",    32'(bif.tx_din),    32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic chk_seq(string nm, bit use_dat, int n,
                           int e0, int e1 = 0, int e2 = 0, int e3 = 0, int e4 = 0);
        int e[5];
        int sz;
        e  = '{e0, e1, e2, e3, e4};
        sz = use_dat ? log_dat.size() : log_id.size();
        chk({nm, "_len"}, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++)
            chk(nm, 32'(use_dat ? log_dat[i] : log_id[i]), 32'(e[i]));
    endtask

    initial begin
        reset = 1'b1;
        bif.req_valid = '0; bif.req_data = '0; bif.req_last = '0;
        bif.tx_done_tick = 1'b0;
        for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; end
        rnd_mode = 1'b0; spur_force = 1'b0; fixed_wait = 3; wait_cnt = 0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // single requester
        push(0, 8'h55, 1'b1);
        run_drain(50);
        chk_seq("single_id", 1'b0, 1, 0);
        chk_seq("single_dat", 1'b1, 1, 'h55);

        // round robin with all four valid
        do_reset();
        push(0, 8'hA0, 1'b1); push(0, 8'hA0, 1'b1);
        push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1); push(3, 8'hA3, 1'b1);
        run_drain(100);
        chk_seq("rr_id", 1'b0, 5, 0, 1, 2, 3, 0);
        chk_seq("rr_dat", 1'b1, 5, 'hA0, 'hA1, 'hA2, 'hA3, 'hA0);

        // late requests arriving while requester 0 transmits
        do_reset();
        fixed_wait = 6;
        push(0, 8'h10, 1'b1);
        cycle(); cycle();
        push(2, 8'h12, 1'b1);
        cycle();
        push(1, 8'h11, 1'b1);
        run_drain(100);
        chk_seq("late_id", 1'b0, 3, 0, 1, 2);

        // packet of three from requester 0 against requester 1
        do_reset();
        fixed_wait = 2;
        push(0, 8'hB0, 1'b0); push(0, 8'hB1, 1'b0); push(0, 8'hB2, 1'b1);
        push(1, 8'hC0, 1'b1); push(1, 8'hC1, 1'b1);
        run_drain(100);
`ifdef UART_TX_ARB_LOCK_EN
        chk_seq("lock_id", 1'b0, 5, 0, 0, 0, 1, 1);
        chk_seq("lock_dat", 1'b1, 5, 'hB0, 'hB1, 'hB2, 'hC0, 'hC1);
`else
        chk_seq("nolock_id", 1'b0, 5, 0, 1, 0, 1, 0);
        chk_seq("nolock_dat", 1'b1, 5, 'hB0, 'hC0, 'hB1, 'hC1, 'hB2);
`endif

        // reset in the middle of a requester-3 transfer
        do_reset();
        fixed_wait = 10;
        push(3, 8'hD3, 1'b1);
        cycle(); cycle(); cycle();
        chk("mid_grant", 32'(bif.grant_id), 32'd3);
        push(1, 8'hE1, 1'b1); push(3, 8'hE3, 1'b1);
        do_reset();
        fixed_wait = 2;
        run_drain(100);
        chk_seq("post_rst_id", 1'b0, 2, 1, 3);
        chk_seq("post_rst_dat", 1'b1, 2, 'hE1, 'hE3);

        // done ticks while idle and while issuing
        do_reset();
        spur_force = 1'b1;
        cycle(); cycle();
        push(0, 8'hF0, 1'b1);
        run_drain(50);
        cycle(); cycle();
        spur_force = 1'b0;
        chk_seq("spur_id", 1'b0, 1, 0);
        chk_seq("spur_dat", 1'b1, 1, 'hF0);

        // randomized traffic
        do_reset();
        rnd_mode = 1'b1;
        repeat (3000) begin
            for (int i = 0; i < NREQ; i++)
                if (tail[i] - head[i] < 8 && $urandom_range(0, 3) == 0)
                    push(i, 8'($urandom), 1'($urandom));
            cycle();
        end
        rnd_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) push(i, 8'hEE, 1'b1);
        run_drain(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
